// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: hold codes, state encoding
// and bus timeout limit.
package pipe_ctrl_pkg;

    localparam int HOLD_FLAG_BUS = 3;
    typedef logic [HOLD_FLAG_BUS-1:0] hold_flag_t;

    localparam hold_flag_t HOLD_NONE = 3'd0;
    localparam hold_flag_t HOLD_PC   = 3'd1;
    localparam hold_flag_t HOLD_IF   = 3'd2;
    localparam hold_flag_t HOLD_ID   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUS_WAIT  = 2'd1,
        ST_LU_BUBBLE = 2'd2,
        ST_DIV_WAIT  = 2'd3
    } state_t;

    localparam int         TIMEOUT_W     = 10;
    localparam logic [9:0] TIMEOUT_LIMIT = 10'd1023;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID source that depends on a load in EX.
module hazard_detect (
    input  logic       ex_load_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_rs1_re_i,
    input  logic       id_rs2_re_i,
    output logic       lu_hit
);

    // x0 is never a real dependency, so a zero destination never hits.
    always_comb begin
        lu_hit = ex_load_i & (ex_rd_i != 5'd0) &
                 ((id_rs1_re_i & (id_rs1_i == ex_rd_i)) |
                  (id_rs2_re_i & (id_rs2_i == ex_rd_i)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/stall/redirect controller.
// Optional bus timeout: define PIPE_CTRL_TIMEOUT_EN to enable the BUS_WAIT watchdog.
//
// state        | meaning
// ST_IDLE      | normal flow, arbitrates stall/jump/load-use/divider/interrupt
// ST_BUS_WAIT  | EX bus access not ready, whole front end frozen
// ST_LU_BUBBLE | second cycle of a load-use hazard, bubble into EX
// ST_DIV_WAIT  | divider running, ID/EX bubbled until it finishes
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        rib_hold_i,
    input  logic        div_busy_i,
    input  logic        clint_hold_i,
    input  logic        ex_load_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_rs1_re_i,
    input  logic        id_rs2_re_i,
    output logic [2:0]  hold_flag_o,
    output logic        stall_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_timeout_o
);

    state_t      state, state_nxt;
    logic        pend, pend_set, pend_clr;
    logic [31:0] pend_addr;
    logic        lu_hit;
    logic        timeout_hit;
    logic        idle_eval;
    hold_flag_t  hold;
    logic        stall, jump;
    logic [31:0] jaddr;

    hazard_detect u_hazard (
        .ex_load_i   (ex_load_i),
        .ex_rd_i     (ex_rd_i),
        .id_rs1_i    (id_rs1_i),
        .id_rs2_i    (id_rs2_i),
        .id_rs1_re_i (id_rs1_re_i),
        .id_rs2_re_i (id_rs2_re_i),
        .lu_hit      (lu_hit)
    );

`ifdef PIPE_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt;

    // Counts consecutive BUS_WAIT cycles; any entry, exit or timeout restarts it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == ST_BUS_WAIT && state_nxt == ST_BUS_WAIT) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_hit   = (state == ST_BUS_WAIT) && (to_cnt == TIMEOUT_LIMIT);
    assign bus_timeout_o = rst & timeout_hit;
`else
    assign timeout_hit   = 1'b0;
    assign bus_timeout_o = 1'b0;
`endif

    // State register and pending-redirect latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pend      <= 1'b0;
            pend_addr <= '0;
        end else begin
            state <= state_nxt;
            if (pend_set) begin
                pend      <= 1'b1;
                pend_addr <= jump_addr_i;
            end else if (pend_clr) begin
                pend <= 1'b0;
            end
        end
    end

    // Next state and outputs; wait states that end this cycle fall back to the
    // IDLE arbitration so the pipeline resumes without a dead cycle.
    always_comb begin
        state_nxt = state;
        hold      = HOLD_NONE;
        stall     = 1'b0;
        jump      = 1'b0;
        jaddr     = '0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        idle_eval = 1'b0;

        case (state)
            ST_IDLE: idle_eval = 1'b1;
            ST_BUS_WAIT: begin
                if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                    pend_set  = jump_flag_i & ~pend;
                end else if (rib_hold_i) begin
                    stall    = 1'b1;
                    pend_set = jump_flag_i & ~pend;
                end else begin
                    idle_eval = 1'b1;
                end
            end
            ST_LU_BUBBLE: begin
                hold      = HOLD_ID;
                state_nxt = ST_IDLE;
                if (jump_flag_i) begin
                    jump  = 1'b1;
                    jaddr = jump_addr_i;
                end
            end
            ST_DIV_WAIT: begin
                if (jump_flag_i) begin
                    jump  = 1'b1;
                    jaddr = jump_addr_i;
                    hold  = HOLD_ID;
                    if (!div_busy_i) state_nxt = ST_IDLE;
                end else if (div_busy_i) begin
                    hold = HOLD_ID;
                end else begin
                    idle_eval = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (idle_eval) begin
            state_nxt = ST_IDLE;
            if (rib_hold_i) begin
                stall     = 1'b1;
                state_nxt = ST_BUS_WAIT;
                pend_set  = jump_flag_i & ~pend;
            end else if (jump_flag_i || pend) begin
                jump     = 1'b1;
                jaddr    = pend ? pend_addr : jump_addr_i;
                hold     = HOLD_ID;
                pend_clr = pend;
            end else if (lu_hit) begin
                hold      = HOLD_IF;
                state_nxt = ST_LU_BUBBLE;
            end else if (div_busy_i) begin
                hold      = HOLD_ID;
                state_nxt = ST_DIV_WAIT;
            end else if (clint_hold_i) begin
                hold = HOLD_ID;
            end
        end
    end

    // Outputs are quiet for as long as reset is held.
    always_comb begin
        hold_flag_o  = rst ? hold : HOLD_NONE;
        stall_flag_o = rst & stall;
        jump_flag_o  = rst & jump;
        jump_addr_o  = rst ? jaddr : 32'd0;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        rib_hold_i, div_busy_i, clint_hold_i, ex_load_i;
    logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
    logic        id_rs1_re_i, id_rs2_re_i;
    logic [2:0]  hold_flag_o;
    logic        stall_flag_o, jump_flag_o, bus_timeout_o;
    logic [31:0] jump_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .rib_hold_i(rib_hold_i), .div_busy_i(div_busy_i), .clint_hold_i(clint_hold_i),
        .ex_load_i(ex_load_i), .ex_rd_i(ex_rd_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
        .hold_flag_o(hold_flag_o), .stall_flag_o(stall_flag_o),
        .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
        .bus_timeout_o(bus_timeout_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: what the pipeline is waiting on, and a remembered redirect.
    bit          m_bus, m_bubble, m_div, m_pend;
    logic [31:0] m_paddr;
    int          m_wait;
    bit          n_bus, n_bubble, n_div, n_pend;
    logic [31:0] n_paddr;
    logic [2:0]  e_hold;
    bit          e_stall, e_jump, e_tout;
    logic [31:0] e_addr;
    logic [2:0]  o_hold;
    bit          o_stall, o_jump, o_tout;
    logic [31:0] o_addr;

    task automatic remember_jump();
        if (jump_flag_i && !m_pend) begin
            n_pend  = 1'b1;
            n_paddr = jump_addr_i;
        end
    endtask

    task automatic model_eval();
        bit hit, free;
        e_hold = HOLD_NONE; e_stall = 0; e_jump = 0; e_addr = 0; e_tout = 0;
        n_bus = 0; n_bubble = 0; n_div = 0; n_pend = m_pend; n_paddr = m_paddr;
        if (!rst) begin
            n_pend = 0;
            return;
        end
        hit = ex_load_i && ex_rd_i != 0 &&
              ((id_rs1_re_i && id_rs1_i == ex_rd_i) || (id_rs2_re_i && id_rs2_i == ex_rd_i));
        free = 1;
        if (m_bus && TO_EN && m_wait == 1023) begin
            e_tout = 1; free = 0; remember_jump();
        end else if (m_bus && rib_hold_i) begin
            e_stall = 1; n_bus = 1; free = 0; remember_jump();
        end else if (m_bubble) begin
            e_hold = HOLD_ID; free = 0;
            if (jump_flag_i) begin e_jump = 1; e_addr = jump_addr_i; end
        end else if (m_div && (jump_flag_i || div_busy_i)) begin
            e_hold = HOLD_ID; free = 0; n_div = div_busy_i;
            if (jump_flag_i) begin e_jump = 1; e_addr = jump_addr_i; end
        end
        if (free) begin
            if (rib_hold_i) begin
                e_stall = 1; n_bus = 1; remember_jump();
            end else if (jump_flag_i || m_pend) begin
                e_jump = 1; e_hold = HOLD_ID;
                e_addr = m_pend ? m_paddr : jump_addr_i;
                n_pend = 0;
            end else if (hit) begin
                e_hold = HOLD_IF; n_bubble = 1;
            end else if (div_busy_i) begin
                e_hold = HOLD_ID; n_div = 1;
            end else if (clint_hold_i) begin
                e_hold = HOLD_ID;
            end
        end
    endtask

    task automatic model_commit();
        m_wait   = (m_bus && n_bus) ? m_wait + 1 : 0;
        m_bus    = n_bus;
        m_bubble = n_bubble;
        m_div    = n_div;
        m_pend   = n_pend;
        m_paddr  = n_paddr;
    endtask

    // Enters just after a rising edge with inputs set, leaves just after the next one.
    task automatic run_cycle();
        @(negedge clk);
        model_eval();
        o_hold = hold_flag_o; o_stall = stall_flag_o; o_jump = jump_flag_o;
        o_addr = jump_addr_o; o_tout = bus_timeout_o;
        chk("hold", {29'd0, o_hold}, {29'd0, e_hold});
        chk("stall", {31'd0, o_stall}, {31'd0, e_stall});
        chk("jump", {31'd0, o_jump}, {31'd0, e_jump});
        if (e_jump) chk("jump_addr", o_addr, e_addr);
        chk("timeout", {31'd0, o_tout}, {31'd0, e_tout});
        chk("jump_vs_stall", {31'd0, o_jump & o_stall}, 32'd0);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic clear_inputs();
        jump_flag_i = 0; jump_addr_i = 0; rib_hold_i = 0; div_busy_i = 0;
        clint_hold_i = 0; ex_load_i = 0; ex_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0;
        id_rs1_re_i = 0; id_rs2_re_i = 0;
    endtask

    int to_cycle;

    initial begin
        rst = 0;
        clear_inputs();
        m_bus = 0; m_bubble = 0; m_div = 0; m_pend = 0; m_paddr = 0; m_wait = 0;
        @(posedge clk); @(posedge clk); #1;
        run_cycle();
        chk("reset_hold", {29'd0, o_hold}, {29'd0, HOLD_NONE});
        rst = 1;

        // Load-use hazard: IF hold, then one bubble, then free.
        ex_load_i = 1; ex_rd_i = 5; id_rs1_i = 5; id_rs1_re_i = 1;
        run_cycle();
        chk("lu_first", {29'd0, o_hold}, {29'd0, HOLD_IF});
        clear_inputs();
        run_cycle();
        chk("lu_bubble", {29'd0, o_hold}, {29'd0, HOLD_ID});
        run_cycle();
        chk("lu_done", {29'd0, o_hold}, {29'd0, HOLD_NONE});

        // Destination x0 never hits.
        ex_load_i = 1; ex_rd_i = 0; id_rs1_i = 5; id_rs1_re_i = 1;
        run_cycle();
        chk("lu_x0_a", {29'd0, o_hold}, {29'd0, HOLD_NONE});
        id_rs1_i = 0;
        run_cycle();
        chk("lu_x0_b", {29'd0, o_hold}, {29'd0, HOLD_NONE});
        clear_inputs();

        // Bus stall for 4 cycles with a redirect in the 2nd; redirect follows once.
        for (int i = 0; i < 4; i++) begin
            rib_hold_i = 1;
            jump_flag_i = (i == 1); jump_addr_i = (i == 1) ? 32'h100 : 32'h0;
            run_cycle();
            chk("bus_stall", {31'd0, o_stall}, 32'd1);
            chk("bus_nojump", {31'd0, o_jump}, 32'd0);
        end
        clear_inputs();
        run_cycle();
        chk("bus_jump", {31'd0, o_jump}, 32'd1);
        chk("bus_jump_addr", o_addr, 32'h100);
        chk("bus_unstall", {31'd0, o_stall}, 32'd0);
        run_cycle();
        chk("bus_jump_once", {31'd0, o_jump}, 32'd0);

        // Divider busy 33 cycles, redirect in cycle 10.
        for (int i = 1; i <= 33; i++) begin
            div_busy_i = 1;
            jump_flag_i = (i == 10); jump_addr_i = (i == 10) ? 32'h2000 : 32'h0;
            run_cycle();
            chk("div_hold", {29'd0, o_hold}, {29'd0, HOLD_ID});
            chk("div_jump", {31'd0, o_jump}, (i == 10) ? 32'd1 : 32'd0);
        end
        clear_inputs();
        run_cycle();
        chk("div_done", {29'd0, o_hold}, {29'd0, HOLD_NONE});

        // Interrupt hold is purely combinational.
        clint_hold_i = 1;
        run_cycle();
        chk("clint_hold", {29'd0, o_hold}, {29'd0, HOLD_ID});
        clear_inputs();
        run_cycle();
        chk("clint_release", {29'd0, o_hold}, {29'd0, HOLD_NONE});

        // Reset in BUS_WAIT with a pending redirect drops everything.
        for (int i = 0; i < 3; i++) begin
            rib_hold_i = 1; jump_flag_i = (i == 1); jump_addr_i = 32'h300;
            run_cycle();
        end
        clear_inputs();
        rst = 0;
        run_cycle();
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            chk("rst_nojump", {31'd0, o_jump}, 32'd0);
            chk("rst_hold", {29'd0, o_hold}, {29'd0, HOLD_NONE});
        end

        // Stuck bus: watchdog pulse when enabled, indefinite stall otherwise.
        to_cycle = -1;
        rib_hold_i = 1;
        for (int i = 0; i < 1100 && to_cycle < 0; i++) begin
            run_cycle();
            if (o_tout) begin
                to_cycle = i;
                chk("to_stall_drop", {31'd0, o_stall}, 32'd0);
            end
        end
        if (TO_EN) chk("to_cycle", to_cycle, 32'd1024);
        else       chk("to_never", to_cycle, 32'hFFFF_FFFF);
        clear_inputs();
        run_cycle();
        run_cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 99) != 0);
            rib_hold_i   = ($urandom_range(0, 99) < 15);
            jump_flag_i  = ($urandom_range(0, 99) < 10);
            jump_addr_i  = $urandom;
            div_busy_i   = ($urandom_range(0, 99) < 12);
            clint_hold_i = ($urandom_range(0, 99) < 10);
            ex_load_i    = ($urandom_range(0, 99) < 35);
            ex_rd_i      = 5'($urandom_range(0, 3));
            id_rs1_i     = 5'($urandom_range(0, 3));
            id_rs2_i     = 5'($urandom_range(0, 3));
            id_rs1_re_i  = 1'($urandom_range(0, 1));
            id_rs2_re_i  = 1'($urandom_range(0, 1));
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk is the only clock; rst is sampled on posedge clk and is active when 0.
REQ-002 Ports, as name  direction  width  meaning:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- jump_flag_i  in  1  EX requests redirect.
- jump_addr_i  in  32  redirect target.
- rib_hold_i  in  1  bus not ready for the EX access.
- div_busy_i  in  1  divider running.
- clint_hold_i  in  1  interrupt controller hold request.
- ex_load_i  in  1  instruction in EX is a load.
- ex_rd_i  in  5  its destination register.
- id_rs1_i, id_rs2_i  in  5 each  ID source registers.
- id_rs1_re_i, id_rs2_re_i  in  1 each  ID reads rs1 or rs2.
- hold_flag_o  out  3  Hold_None/Hold_Pc/Hold_If/Hold_Id; a value of Hold_Id or above bubbles the ID/EX register.
- stall_flag_o  out  1  freezes PC, IF/ID and ID/EX.
- jump_flag_o  out  1  redirect PC.
- jump_addr_o  out  32  redirect target.
- bus_timeout_o  out  1  one-cycle timeout pulse.

Function
REQ-003 SHALL implement FSM states IDLE, BUS_WAIT, LU_BUBBLE and DIV_WAIT, held in a registered state variable.
REQ-004 SHALL compute lu_hit combinationally as ex_load_i & (ex_rd_i != 0) & ((id_rs1_re_i & id_rs1_i == ex_rd_i) | (id_rs2_re_i & id_rs2_i == ex_rd_i)).
REQ-005 IDLE outputs, by priority:
- rib_hold_i: stall_flag_o=1 in the same cycle; next state BUS_WAIT.
- else jump_flag_i or a pending jump: jump_flag_o=1, jump_addr_o=target, hold_flag_o=Hold_Id.
- else lu_hit: hold_flag_o=Hold_If; next state LU_BUBBLE.
- else div_busy_i: hold_flag_o=Hold_Id; next state DIV_WAIT.
- else clint_hold_i: hold_flag_o=Hold_Id (combinational only, no state change).
- else: all outputs 0 / Hold_None.
REQ-006 BUS_WAIT SHALL hold stall_flag_o=1 while rib_hold_i=1, return to IDLE in the cycle after rib_hold_i falls, and deassert stall_flag_o in that same cycle.
REQ-007 A jump_flag_i seen during BUS_WAIT SHALL latch a pending flag and the target, first request wins, and SHALL be issued in the first IDLE cycle; the pending flag clears on issue.
REQ-008 LU_BUBBLE SHALL last exactly 1 cycle with hold_flag_o=Hold_Id, inserting a bubble in EX, then return to IDLE; lu_hit is ignored during this cycle.
REQ-009 DIV_WAIT SHALL hold hold_flag_o=Hold_Id until div_busy_i=0, then return to IDLE; jump_flag_i in DIV_WAIT overrides the hold and is issued immediately per REQ-005.
REQ-010 jump_flag_o SHALL never be asserted in the same cycle as stall_flag_o.
REQ-011 Simultaneous rib_hold_i and jump_flag_i in IDLE: the stall wins and the jump becomes pending.

Reset
REQ-012 With rst=0 at posedge clk: state=IDLE, pending jump cleared, timeout counter=0, and every output 0 (hold_flag_o=Hold_None) in the following cycle, including when reset arrives mid-BUS_WAIT.

Configuration
REQ-013 With PIPE_CTRL_TIMEOUT_EN defined, a 10-bit counter SHALL count cycles in BUS_WAIT. On reaching 1023 it SHALL pulse bus_timeout_o for 1 cycle, force IDLE and clear the counter; the counter also clears on every entry to BUS_WAIT.
REQ-014 Without PIPE_CTRL_TIMEOUT_EN, no counter SHALL exist, bus_timeout_o SHALL be tied to 0, and BUS_WAIT SHALL wait indefinitely.

Structure
REQ-015 Hold_* codes, Hold_Flag_Bus, the state encoding and the timeout limit SHALL live in the shared defines header.
REQ-016 The load-use comparator SHALL be a sub-module, hazard_detect, that is purely combinational; the FSM stays in pipe_ctrl.

Verification
REQ-017 ex_load_i=1, ex_rd_i=5, id_rs1_i=5, id_rs1_re_i=1 -> hold_flag_o=Hold_If for 1 cycle, then Hold_Id for 1 cycle, then Hold_None.
REQ-018 Same stimulus as REQ-017 with ex_rd_i=0 -> no hold.
REQ-019 rib_hold_i=1 for 4 cycles with jump_flag_i=1, jump_addr_i=0x100 in the 2nd cycle -> stall_flag_o=1 for 4 cycles, then jump_flag_o=1 with 0x100 in the next cycle, exactly once.
REQ-020 div_busy_i=1 for 33 cycles -> hold_flag_o=Hold_Id for 33 cycles; with jump_flag_i at cycle 10 -> jump_flag_o=1 in cycle 10.
REQ-021 PIPE_CTRL_TIMEOUT_EN defined, rib_hold_i stuck at 1 -> bus_timeout_o pulses after 1023 BUS_WAIT cycles and stall_flag_o drops.
REQ-022 rst=0 asserted during BUS_WAIT with a pending jump -> all outputs 0 next cycle, and no jump issued after reset.
